// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_LW, OP_I: imm = IMM_I;
      OP_SW:       imm = IMM_S;
      OP_BR:       imm = IMM_B;
      OP_JAL:      imm = IMM_J;
      default:     imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALUOp/funct to ALUControl translation, purely combinational.
module mc_alu_decoder
  import rv_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct_3,
  input  logic                 funct_7,
  input  logic                 op_5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] code_s;

  // Select the ALU operation; only R-type with funct7 set turns funct3=000 into sub.
  always_comb begin
    code_s = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: code_s = ALU_ADD;
      ALUOP_SUB: code_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_3)
          3'b000: begin
            if (op_5 && funct_7) begin
              code_s = ALU_SUB;
            end else begin
              code_s = ALU_ADD;
            end
          end
          3'b010:  code_s = ALU_SLT;
          3'b110:  code_s = ALU_OR;
          3'b111:  code_s = ALU_AND;
          default: code_s = ALU_ADD;
        endcase
      end
      default: code_s = ALU_ADD;
    endcase
  end

  assign alu_control = ALUCTRL_W'(code_s);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with cache-ready handshake and stall watchdog.
module multicycle_control_unit
  import rv_mc_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int EN_BNE        = 1,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct_3,
  input  logic                 funct_7,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal_instr,
  output logic                 mem_timeout
);

  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STALL_TIMEOUT);
  localparam bit               WD_ON  = (STALL_TIMEOUT != 0);
  localparam bit               BNE_ON = (EN_BNE != 0);

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             timeout_r;
  logic             wait_s;
  logic             pc_write_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;
  logic             adr_src_s, illegal_s;
  logic [1:0]       result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_state_s = state_r;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RS2;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        mem_read_s   = 1'b1;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        if (mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_R:         next_state_s = EXECR;
          OP_I:         next_state_s = EXECI;
          OP_BR:        next_state_s = BRANCH;
          OP_JAL:       next_state_s = JAL;
          default: begin
            next_state_s = FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        if (op == OP_LW) begin
          next_state_s = MEMREAD;
        end else if (op == OP_SW) begin
          next_state_s = MEMWRITE;
        end else begin
          next_state_s = FETCH;
        end
      end
      MEMREAD: begin
        adr_src_s  = 1'b1;
        mem_read_s = 1'b1;
        if (mem_ready) begin
          next_state_s = MEMWB;
        end else begin
          next_state_s = MEMREAD;
        end
      end
      MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEMWRITE;
        end
      end
      EXECR: begin
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALUOP_FUNCT;
        next_state_s = ALUWB;
      end
      EXECI: begin
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_IMM;
        alu_op_s     = ALUOP_FUNCT;
        next_state_s = ALUWB;
      end
      ALUWB: begin
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      BRANCH: begin
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALUOP_SUB;
        next_state_s = FETCH;
        if (funct_3 == 3'b000) begin
          pc_write_s = Zero;
        end else if ((funct_3 == 3'b001) && BNE_ON) begin
          pc_write_s = ~Zero;
        end else begin
          illegal_s = 1'b1;
        end
      end
      JAL: begin
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        pc_write_s   = 1'b1;
        next_state_s = ALUWB;
      end
      default: next_state_s = FETCH;
    endcase
  end

  assign wait_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);

  // Stall counter: counts consecutive not-ready cycles in a wait state, saturating at the limit.
  always_comb begin
    if (wait_s && !mem_ready) begin
      if (cnt_r == LIMIT) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Watchdog state; the timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (WD_ON && (cnt_nxt_s == LIMIT)) begin
        timeout_r <= 1'b1;
      end
    end
  end

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .alu_op      (alu_op_s),
    .funct_3     (funct_3),
    .funct_7     (funct_7),
    .op_5        (op[5]),
    .alu_control (ALUControl)
  );

  // Enables and memory requests are forced low the instant reset asserts.
  assign PCWrite       = pc_write_s  & rst_n;
  assign IRWrite       = ir_write_s  & rst_n;
  assign RegWrite      = reg_write_s & rst_n;
  assign MemWrite      = mem_write_s & rst_n;
  assign MemRead       = mem_read_s  & rst_n;
  assign AdrSrc        = adr_src_s;
  assign ResultSrc     = result_src_s;
  assign ALUSrcA       = alu_src_a_s;
  assign ALUSrcB       = alu_src_b_s;
  assign ImmSrc        = imm_src_of(op);
  assign illegal_instr = illegal_s;
  assign mem_timeout   = timeout_r;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control unit.
- FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Memory states hold on a cache ready handshake, so instruction fetch, load and store may stall on a write-through cache miss.
- Adds parametrised bne support and a stall-timeout watchdog.

Parameters:
- ALUCTRL_W, 3, width of ALUControl output.
- EN_BNE, 1, when 1 funct3=001 on branch opcode is bne; when 0 it is illegal.
- STALL_TIMEOUT, 255, max cycles in any wait state before mem_timeout is flagged; 0 disables the watchdog.
- CNT_W, 8, stall counter width; must hold STALL_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode from the instruction register.
- funct_3  in  3  instr[14:12].
- funct_7  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  cache has completed the current read/write this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction/OldPC register enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J (decoded from op, every state).
- RegWrite  out  1  register file write enable.
- ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct3.
- mem_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, stall counter=0, mem_timeout=0, illegal_instr=0. All enables (PCWrite, IRWrite, RegWrite, MemWrite) are 0 while rst_n=0.
- Unlisted outputs are 0 in every state.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite assert only when mem_ready=1, then go to DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FETCH, with illegal_instr=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, MemRead=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, then FETCH.
  - PCWrite = Zero for funct3=000; PCWrite = ~Zero for funct3=001 when EN_BNE=1.
  - Any other funct3: illegal_instr pulse, PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB.
- ALU decode (combinational):
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct_3: 000 -> sub if {op[5],funct_7}=11, else add; 010 -> slt; 110 -> or; 111 -> and; others -> add.
- Latency in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4, each plus stall cycles.
- Watchdog:
  - Counter increments each cycle spent in FETCH/MEMREAD/MEMWRITE with mem_ready=0; clears on mem_ready=1 or state change.
  - Saturates at STALL_TIMEOUT and sets mem_timeout, which clears only on reset. The FSM keeps waiting.
- mem_ready while not in a wait state is ignored.
- Reset asserted mid-stall aborts the access; MemRead/MemWrite drop asynchronously.

Decomposition:
- Package rv_mc_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL), 4-bit encoding;
  - opcode constants;
  - ALUControl codes;
  - ResultSrc/ALUSrcA/ALUSrcB encodings.
- Sub-module mc_alu_decoder: pure combinational ALUOp/funct -> ALUControl.
- FSM, output decode and watchdog stay in the top module.

Test Plan:
- add x3,x1,x2 (op=0110011, f3=000, f7=0), mem_ready=1 -> states F,D,EXECR,ALUWB; RegWrite=1 in cycle 4; ALUControl=000 in EXECR.
- lw with mem_ready low 3 cycles in MEMREAD -> MemRead=1, AdrSrc=1 held 4 cycles; MEMWB on cycle 8; RegWrite=1 once, ResultSrc=01.
- beq with Zero=1 -> PCWrite=1 in BRANCH, ALUControl=001; repeat with bne (f3=001), Zero=1 -> PCWrite=0.
- op=1111111 -> illegal_instr=1 in DECODE, next state FETCH, no RegWrite/MemWrite.
- FETCH with mem_ready=0 for 256 cycles (STALL_TIMEOUT=255) -> mem_timeout=1 at cycle 255 and stays set; IRWrite=0 throughout.
- rst_n low mid-MEMWRITE stall -> MemWrite=0 immediately; after release, state=FETCH, mem_timeout=0.
